// File: rtl/register_file_32x32.sv
// 32-entry x 32-bit register file.
// One synchronous write port and two independent registered read ports (A, B).
// A read that hits the address being written in the same cycle returns the new
// write data (write-first bypass). Entry 0 is an ordinary writable register.
module register_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_w,
  input  logic              enable_w,
  input  logic [DATA_W-1:0] In,
  input  logic [ADDR_W-1:0] address_a,
  input  logic              enable_a,
  output logic [DATA_W-1:0] OutA,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              enable_b,
  output logic [DATA_W-1:0] OutB
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] outa_q, outa_d;
  logic [DATA_W-1:0] outb_q, outb_d;
  logic              hit_a, hit_b;

  assign hit_a = enable_w && (address_w == address_a);
  assign hit_b = enable_w && (address_w == address_b);

  // Read-port next values: hold when disabled, bypass write data on address hit.
  always_comb begin
    outa_d = outa_q;
    outb_d = outb_q;
    if (enable_a) begin
      outa_d = hit_a ? In : mem_q[address_a];
    end
    if (enable_b) begin
      outb_d = hit_b ? In : mem_q[address_b];
    end
  end

  // Storage and output registers; reset clears everything and drops any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
      outa_q <= '0;
      outb_q <= '0;
    end else begin
      if (enable_w) begin
        mem_q[address_w] <= In;
      end
      outa_q <= outa_d;
      outb_q <= outb_d;
    end
  end

  assign OutA = outa_q;
  assign OutB = outb_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed bench for register_file_32x32.
module tb_register_file_32x32;

  logic        clk;
  logic        rst;
  logic [4:0]  address_w;
  logic        enable_w;
  logic [31:0] In;
  logic [4:0]  address_a;
  logic        enable_a;
  logic [31:0] OutA;
  logic [4:0]  address_b;
  logic        enable_b;
  logic [31:0] OutB;

  int total;
  int bad;

  register_file_32x32 #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_w(address_w),
    .enable_w (enable_w),
    .In       (In),
    .address_a(address_a),
    .enable_a (enable_a),
    .OutA     (OutA),
    .address_b(address_b),
    .enable_b (enable_b),
    .OutB     (OutB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    address_w = '0;
    enable_w  = 1'b0;
    In        = '0;
    address_a = '0;
    enable_a  = 1'b0;
    address_b = '0;
    enable_b  = 1'b0;

    // 1. Reset, then read every address on A
    tick();
    check("reset_outa", OutA, 32'h0);
    check("reset_outb", OutB, 32'h0);
    rst      = 1'b0;
    enable_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      address_a = 5'(i);
      tick();
      check($sformatf("reset_mem_a%0d", i), OutA, 32'h0);
    end
    enable_a = 1'b0;

    // 2. Fill all entries, read back 0..15 on A and 16..31 on B
    enable_w = 1'b1;
    for (int i = 0; i < 32; i++) begin
      address_w = 5'(i);
      In        = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    enable_w = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      address_a = 5'(i);
      address_b = 5'(i + 16);
      tick();
      check($sformatf("fill_a%0d", i), OutA, 32'hA5A5_0000 + 32'(i));
      check($sformatf("fill_b%0d", i + 16), OutB, 32'hA5A5_0010 + 32'(i));
    end

    // 3. Write-first bypass on both ports at addr 7
    enable_w  = 1'b1;
    address_w = 5'd7;
    In        = 32'hDEAD_BEEF;
    address_a = 5'd7;
    address_b = 5'd7;
    tick();
    check("bypass_both_a", OutA, 32'hDEAD_BEEF);
    check("bypass_both_b", OutB, 32'hDEAD_BEEF);
    // bypass on A only; B reads an unrelated address
    address_w = 5'd20;
    In        = 32'hCAFE_F00D;
    address_a = 5'd20;
    address_b = 5'd21;
    tick();
    check("bypass_a_only", OutA, 32'hCAFE_F00D);
    check("no_bypass_b", OutB, 32'hA5A5_0015);
    // stored values read back without a concurrent write
    enable_w  = 1'b0;
    address_a = 5'd7;
    address_b = 5'd20;
    tick();
    check("stored_7", OutA, 32'hDEAD_BEEF);
    check("stored_20", OutB, 32'hCAFE_F00D);

    // 4. Hold OutA with enable_a low while address_a moves
    enable_a  = 1'b0;
    enable_b  = 1'b0;
    enable_w  = 1'b1;
    address_w = 5'd10;
    In        = 32'h1234_5678;
    tick();
    enable_w  = 1'b0;
    enable_a  = 1'b1;
    address_a = 5'd10;
    tick();
    check("set_outa", OutA, 32'h1234_5678);
    enable_a  = 1'b0;
    address_a = 5'd11;
    tick();
    check("hold_outa_1", OutA, 32'h1234_5678);
    address_a = 5'd0;
    tick();
    check("hold_outa_2", OutA, 32'h1234_5678);
    check("hold_outb", OutB, 32'hCAFE_F00D);

    // 5. Disabled write leaves memory untouched
    enable_w  = 1'b1;
    address_w = 5'd3;
    In        = 32'h0000_0003;
    tick();
    enable_w  = 1'b0;
    In        = 32'hFFFF_FFFF;
    tick();
    enable_a  = 1'b1;
    address_a = 5'd3;
    tick();
    check("no_write_3", OutA, 32'h0000_0003);

    // 6. Reset wins over a same-cycle write and over read enables
    enable_b  = 1'b1;
    address_b = 5'd9;
    tick();
    check("pre_reset_9", OutB, 32'hA5A5_0009);
    rst       = 1'b1;
    enable_w  = 1'b1;
    address_w = 5'd9;
    In        = 32'h0000_0055;
    address_a = 5'd9;
    tick();
    check("rst_outa", OutA, 32'h0);
    check("rst_outb", OutB, 32'h0);
    rst       = 1'b0;
    enable_w  = 1'b0;
    address_a = 5'd9;
    address_b = 5'd7;
    tick();
    check("post_rst_9", OutA, 32'h0);
    check("post_rst_7", OutB, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
